fib_seq_stream: RTL and testbench
=================================

// Module: fib_seq_stream
// PURPOSE
//  Parametrised Fibonacci/Lucas term generator; next generation of the 4-bit Fibonacci FSM.
//  Produces N terms of a selectable sequence at up to one term per clock.
//  Terms leave on a valid/ready stream; overflow is detected with optional saturation.
//  Sits between the control sequencer (START/Done) and any downstream consumer of terms.
// PARAMETERS
//  WIDTH     4  data width of each term, in bits
//  CNT_W     4  width of the term-count and term-index fields
//  SATURATE  0  0 = wrap terms modulo 2^WIDTH; 1 = clamp terms to all-ones
// PORTS
//  Clk         in   1      single clock; all state updates on posedge Clk
//  Rst         in   1      synchronous, active-high reset
//  START       in   1      start request; sampled only in IDLE
//  num_terms   in   CNT_W  number of terms N; latched when START is accepted
//  mode        in   1      0 = Fibonacci (seeds 0,1); 1 = Lucas (seeds 2,1); latched with START
//  data_ready  in   1      consumer ready
//  data        out  WIDTH  current term
//  data_valid  out  1      data holds a valid term
//  term_idx    out  CNT_W  index (0..N-1) of the term on data
//  overflow    out  1      sticky: some term presented in this run did not fit in WIDTH bits
//  Busy        out  1      high whenever state != IDLE
//  Done        out  1      one-cycle pulse when a run completes
// BEHAVIOUR
//  Reset values: all outputs 0; state IDLE; internal registers 0.
//  FSM states: IDLE -> LOAD -> RUN -> DONE -> IDLE.
//  - IDLE: START=1 at an edge moves to LOAD. That edge also latches num_terms/mode,
//    clears overflow, and clears term_idx.
//  - LOAD (1 cycle): prev <= seed0, cur <= seed1, ovf tags cleared. If N==0, go to DONE;
//    otherwise go to RUN.
//  - RUN: data_valid=1 and data=prev. A transfer occurs on any edge with data_valid && data_ready.
//    On transfer: prev <= cur; cur <= f(prev+cur); term_idx <= term_idx+1.
//    A transfer at term_idx==N-1 goes to DONE instead, with no further update.
//  - DONE (1 cycle): Done=1, data_valid=0, then IDLE. overflow and data stay held until the next START.
//  Latency and throughput:
//  - START accepted at edge t: data_valid first high after edge t+1.
//  - With data_ready held high, one term per cycle; Done is high in the cycle after the last transfer.
//  Handshake rules:
//  - While data_valid && !data_ready: data and term_idx are held stable.
//  - data_valid never drops before a transfer.
//  - data_ready is ignored outside RUN.
//  Arithmetic:
//  - The sum is computed at WIDTH+1 bits. Each of prev and cur carries an ovf tag.
//  - new tag = carry | tag(prev) | tag(cur).
//  - If the tag is set: SATURATE=0 keeps the low WIDTH bits; SATURATE=1 forces all-ones.
//  - overflow is set in the cycle a tagged term is first presented on data, and stays set (sticky).
//  Boundary conditions:
//  - START outside IDLE is ignored; it has no effect on N, mode or data.
//  - N==0: no data_valid; Done pulses 2 cycles after START is accepted.
//  - N==2^CNT_W-1 is the maximum; term_idx never wraps within a run.
//  - Rst asserted in any state: at the next edge all outputs return to reset values. No Done pulse, no partial transfer.
//  - Rst and START high at the same edge: Rst wins.
//  - Rst and a transfer at the same edge: Rst wins.
// TESTING
//  T1 WIDTH=8, mode0, N=8, ready=1: data 0,1,1,2,3,5,8,13 on 8 consecutive cycles, term_idx 0..7,
//     Done one cycle after the 13 transfer, overflow=0.
//  T2 As T1 with ready toggling 1,0,0,1,...: same sequence. data/term_idx stable on every
//     valid&&!ready cycle; no term skipped or repeated.
//  T3 mode1, N=5: data 2,1,3,4,7; Done pulse; Busy high from the cycle after START through DONE.
//  T4 WIDTH=4, N=10, mode0, SATURATE=0: ...,8,13,5,2. overflow rises with term_idx=8 and stays 1.
//     SATURATE=1: ...,8,13,15,15.
//  T5 N=0: no data_valid; Done 2 cycles after START. Second START pulsed during RUN of N=6:
//     ignored, exactly 6 terms emitted.
//  T6 Rst for 1 cycle at term_idx=3 with ready=1: all outputs 0 at the next edge, no Done.
//     A new START then restarts from term 0.

Source files
------------

// File: rtl/fib_seq_stream_if.sv
// Term stream and run-control bundle between the sequencer, the generator and the consumer.
interface fib_seq_stream_if #(
    parameter int unsigned WIDTH = 4,
    parameter int unsigned CNT_W = 4
);
    logic             START;
    logic [CNT_W-1:0] num_terms;
    logic             mode;
    logic             data_ready;
    logic [WIDTH-1:0] data;
    logic             data_valid;
    logic [CNT_W-1:0] term_idx;
    logic             overflow;
    logic             Busy;
    logic             Done;

    // Generator side: produces terms and run status
    modport master (
        input  START, num_terms, mode, data_ready,
        output data, data_valid, term_idx, overflow, Busy, Done
    );

    // Sequencer/consumer side
    modport slave (
        output START, num_terms, mode, data_ready,
        input  data, data_valid, term_idx, overflow, Busy, Done
    );
endinterface

// File: rtl/fib_seq_stream.sv
// Fibonacci/Lucas term generator streaming N terms over valid/ready, with overflow tagging.
module fib_seq_stream #(
    parameter int unsigned WIDTH    = 4,
    parameter int unsigned CNT_W    = 4,
    parameter bit          SATURATE = 1'b0
) (
    input  logic              Clk,
    input  logic              Rst,
    fib_seq_stream_if.master  bus
);
    localparam logic [1:0] S_IDLE = 2'd0;
    localparam logic [1:0] S_LOAD = 2'd1;
    localparam logic [1:0] S_RUN  = 2'd2;
    localparam logic [1:0] S_DONE = 2'd3;

    localparam logic [WIDTH-1:0] SEED_FIB0 = '0;
    localparam logic [WIDTH-1:0] SEED_LUC0 = WIDTH'(2);
    localparam logic [WIDTH-1:0] SEED_1    = WIDTH'(1);
    localparam logic [WIDTH-1:0] ALL_ONES  = '1;

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] n_q, n_d;
    logic             mode_q, mode_d;
    logic [WIDTH-1:0] prev_q, prev_d;
    logic [WIDTH-1:0] cur_q, cur_d;
    logic             prev_tag_q, prev_tag_d;
    logic             cur_tag_q, cur_tag_d;
    logic [CNT_W-1:0] idx_q, idx_d;
    logic             ovf_q, ovf_d;
    logic             valid_q, valid_d;
    logic             busy_q, busy_d;
    logic             done_q, done_d;

    logic [WIDTH:0]   sum_c;
    logic             tag_c;
    logic [WIDTH-1:0] next_c;
    logic             xfer_c;

    // Next-state, datapath and registered-output decode
    always_comb begin
        state_d    = state_q;
        n_d        = n_q;
        mode_d     = mode_q;
        prev_d     = prev_q;
        cur_d      = cur_q;
        prev_tag_d = prev_tag_q;
        cur_tag_d  = cur_tag_q;
        idx_d      = idx_q;
        ovf_d      = ovf_q;

        // Sum carries one extra bit so the carry out doubles as the overflow tag source
        sum_c  = {1'b0, prev_q} + {1'b0, cur_q};
        tag_c  = sum_c[WIDTH] | prev_tag_q | cur_tag_q;
        next_c = (tag_c && SATURATE) ? ALL_ONES : sum_c[WIDTH-1:0];
        xfer_c = valid_q && bus.data_ready;

        case (state_q)
            S_IDLE: begin
                if (bus.START) begin
                    state_d = S_LOAD;
                    n_d     = bus.num_terms;
                    mode_d  = bus.mode;
                    ovf_d   = 1'b0;
                    idx_d   = '0;
                end
            end
            S_LOAD: begin
                prev_d     = mode_q ? SEED_LUC0 : SEED_FIB0;
                cur_d      = SEED_1;
                prev_tag_d = 1'b0;
                cur_tag_d  = 1'b0;
                state_d    = (n_q == '0) ? S_DONE : S_RUN;
            end
            S_RUN: begin
                if (xfer_c) begin
                    if (idx_q == CNT_W'(n_q - CNT_W'(1))) begin
                        state_d = S_DONE;
                    end else begin
                        prev_d     = cur_q;
                        cur_d      = next_c;
                        prev_tag_d = cur_tag_q;
                        cur_tag_d  = tag_c;
                        idx_d      = CNT_W'(idx_q + CNT_W'(1));
                    end
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Overflow latches in the same cycle a tagged term becomes visible on data
        if (state_d == S_RUN && prev_tag_d) begin
            ovf_d = 1'b1;
        end

        valid_d = (state_d == S_RUN);
        busy_d  = (state_d != S_IDLE);
        done_d  = (state_d == S_DONE);
    end

    // State and output registers with synchronous reset
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state_q    <= S_IDLE;
            n_q        <= '0;
            mode_q     <= 1'b0;
            prev_q     <= '0;
            cur_q      <= '0;
            prev_tag_q <= 1'b0;
            cur_tag_q  <= 1'b0;
            idx_q      <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            n_q        <= n_d;
            mode_q     <= mode_d;
            prev_q     <= prev_d;
            cur_q      <= cur_d;
            prev_tag_q <= prev_tag_d;
            cur_tag_q  <= cur_tag_d;
            idx_q      <= idx_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
        end
    end

    assign bus.data       = prev_q;
    assign bus.data_valid = valid_q;
    assign bus.term_idx   = idx_q;
    assign bus.overflow   = ovf_q;
    assign bus.Busy       = busy_q;
    assign bus.Done       = done_q;

endmodule

// File: tb/tb_fib_seq_stream.sv
// Bench for fib_seq_stream: three configurations driven in lockstep, checked against an
// arithmetic reference built from unbounded Fibonacci/Lucas values.
module tb_fib_seq_stream;
    logic       Clk = 1'b0;
    logic       Rst;
    logic       start;
    logic [3:0] num_terms;
    logic       mode;
    logic       ready;

    int n_cmp = 0;
    int n_err = 0;

    int cfg_w   [3] = '{8, 4, 4};
    bit cfg_sat [3] = '{1'b0, 1'b0, 1'b1};

    always #5 Clk = ~Clk;

    fib_seq_stream_if #(.WIDTH(8), .CNT_W(4)) b0 ();
    fib_seq_stream_if #(.WIDTH(4), .CNT_W(4)) b1 ();
    fib_seq_stream_if #(.WIDTH(4), .CNT_W(4)) b2 ();

    assign b0.START = start;  assign b0.num_terms = num_terms;
    assign b0.mode  = mode;   assign b0.data_ready = ready;
    assign b1.START = start;  assign b1.num_terms = num_terms;
    assign b1.mode  = mode;   assign b1.data_ready = ready;
    assign b2.START = start;  assign b2.num_terms = num_terms;
    assign b2.mode  = mode;   assign b2.data_ready = ready;

    fib_seq_stream #(.WIDTH(8), .CNT_W(4), .SATURATE(1'b0)) dut0 (.Clk(Clk), .Rst(Rst), .bus(b0));
    fib_seq_stream #(.WIDTH(4), .CNT_W(4), .SATURATE(1'b0)) dut1 (.Clk(Clk), .Rst(Rst), .bus(b1));
    fib_seq_stream #(.WIDTH(4), .CNT_W(4), .SATURATE(1'b1)) dut2 (.Clk(Clk), .Rst(Rst), .bus(b2));

    // Unbounded k-th term of the chosen sequence
    function automatic longint true_term(input bit m, input int k);
        longint a = m ? 64'sd2 : 64'sd0;
        longint b = 64'sd1;
        longint t;
        for (int i = 0; i < k; i++) begin
            t = a + b;
            a = b;
            b = t;
        end
        return a;
    endfunction

    function automatic bit exp_tag(input int id, input bit m, input int k);
        longint lim = longint'(1) << cfg_w[id];
        return true_term(m, k) >= lim;
    endfunction

    function automatic logic [31:0] exp_data(input int id, input bit m, input int k);
        longint lim = longint'(1) << cfg_w[id];
        longint v   = true_term(m, k);
        if (v >= lim && cfg_sat[id]) return 32'(lim - 1);
        return 32'(v % lim);
    endfunction

    function automatic bit exp_ovf(input int id, input bit m, input int k);
        bit o = 1'b0;
        for (int j = 0; j <= k; j++) o = o | exp_tag(id, m, j);
        return o;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic sample(input int id, output logic [31:0] d, output logic v,
                          output logic [31:0] ix, output logic ov, output logic bs,
                          output logic dn);
        case (id)
            0: begin d = 32'(b0.data); v = b0.data_valid; ix = 32'(b0.term_idx);
                     ov = b0.overflow; bs = b0.Busy; dn = b0.Done; end
            1: begin d = 32'(b1.data); v = b1.data_valid; ix = 32'(b1.term_idx);
                     ov = b1.overflow; bs = b1.Busy; dn = b1.Done; end
            default: begin d = 32'(b2.data); v = b2.data_valid; ix = 32'(b2.term_idx);
                     ov = b2.overflow; bs = b2.Busy; dn = b2.Done; end
        endcase
    endtask

    // dk: term index expected on data (-1 => 0, -2 => unchecked); ok: overflow up to term (-1 => 0)
    task automatic check(input string tag, input bit ev, input bit eb, input bit ed,
                         input int eidx, input int dk, input int ok, input bit m);
        logic [31:0] d, ix;
        logic v, ov, bs, dn;
        logic [31:0] ed_v;
        bit eo;
        for (int id = 0; id < 3; id++) begin
            sample(id, d, v, ix, ov, bs, dn);
            chk($sformatf("%s.d%0d.valid", tag, id), 32'(v),  32'(ev));
            chk($sformatf("%s.d%0d.busy",  tag, id), 32'(bs), 32'(eb));
            chk($sformatf("%s.d%0d.done",  tag, id), 32'(dn), 32'(ed));
            chk($sformatf("%s.d%0d.idx",   tag, id), ix, 32'(eidx));
            if (dk != -2) begin
                if (dk == -1) ed_v = 32'd0;
                else          ed_v = exp_data(id, m, dk);
                chk($sformatf("%s.d%0d.data", tag, id), d, ed_v);
            end
            if (ok < 0) eo = 1'b0;
            else        eo = exp_ovf(id, m, ok);
            chk($sformatf("%s.d%0d.ovf", tag, id), 32'(ov), 32'(eo));
        end
    endtask

    // One run: rdy_mode 0 = always ready, 1 = pattern 1,0,0, 2 = random
    task automatic run(input string tag, input int n, input bit m, input int rdy_mode,
                       input bit inject, input int rst_at);
        int  k = 0;
        int  cyc = 0;
        int  stalls = 0;
        bit  r;
        start = 1'b1; num_terms = 4'(n); mode = m; ready = 1'($urandom);
        @(posedge Clk); #1;
        start = 1'b0; num_terms = 4'($urandom); mode = 1'($urandom);
        check({tag, ".load"}, 1'b0, 1'b1, 1'b0, 0, -2, -1, m);
        @(posedge Clk); #1;
        while (k < n) begin
            check($sformatf("%s.t%0d", tag, k), 1'b1, 1'b1, 1'b0, k, k, k, m);
            if (k == rst_at) begin
                ready = 1'b1; Rst = 1'b1;
                @(posedge Clk); #1;
                Rst = 1'b0;
                check({tag, ".rst"}, 1'b0, 1'b0, 1'b0, 0, -1, -1, m);
                @(posedge Clk); #1;
                check({tag, ".postrst"}, 1'b0, 1'b0, 1'b0, 0, -1, -1, m);
                return;
            end
            case (rdy_mode)
                0:       r = 1'b1;
                1:       r = (cyc % 3 == 0);
                default: r = (($urandom % 100) < 60) || (stalls >= 8);
            endcase
            stalls = r ? 0 : stalls + 1;
            if (inject && cyc == 3) begin
                start = 1'b1; num_terms = 4'($urandom); mode = ~m;
            end
            ready = r;
            @(posedge Clk); #1;
            start = 1'b0;
            if (r) k++;
            cyc++;
        end
        ready = 1'($urandom);
        if (n == 0) begin
            check({tag, ".done"}, 1'b0, 1'b1, 1'b1, 0, 0, -1, m);
            @(posedge Clk); #1;
            check({tag, ".idle"}, 1'b0, 1'b0, 1'b0, 0, 0, -1, m);
        end else begin
            check({tag, ".done"}, 1'b0, 1'b1, 1'b1, n - 1, n - 1, n - 1, m);
            @(posedge Clk); #1;
            check({tag, ".idle"}, 1'b0, 1'b0, 1'b0, n - 1, n - 1, n - 1, m);
        end
    endtask

    initial begin
        Rst = 1'b1; start = 1'b0; num_terms = '0; mode = 1'b0; ready = 1'b0;
        repeat (2) @(posedge Clk);
        #1;
        Rst = 1'b0;
        check("reset", 1'b0, 1'b0, 1'b0, 0, -1, -1, 1'b0);

        run("T1", 8, 1'b0, 0, 1'b0, -1);
        run("T2", 8, 1'b0, 1, 1'b0, -1);
        run("T3", 5, 1'b1, 0, 1'b0, -1);
        run("T4", 10, 1'b0, 0, 1'b0, -1);
        run("T5a", 0, 1'b0, 0, 1'b0, -1);
        run("T5b", 6, 1'b0, 2, 1'b1, -1);
        run("T6a", 8, 1'b0, 0, 1'b0, 3);
        run("T6b", 8, 1'b0, 0, 1'b0, -1);
        run("MAXF", 15, 1'b0, 2, 1'b0, -1);
        run("MAXL", 15, 1'b1, 2, 1'b1, -1);

        // Reset and START at the same edge: reset wins, generator stays idle
        Rst = 1'b1; start = 1'b1; num_terms = 4'd5; mode = 1'b0;
        @(posedge Clk); #1;
        Rst = 1'b0; start = 1'b0;
        check("rststart", 1'b0, 1'b0, 1'b0, 0, -1, -1, 1'b0);
        @(posedge Clk); #1;
        check("rststart2", 1'b0, 1'b0, 1'b0, 0, -1, -1, 1'b0);

        for (int i = 0; i < 8; i++) begin
            run($sformatf("R%0d", i), int'($urandom_range(0, 15)), 1'($urandom), 2,
                1'($urandom), -1);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
